// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives imem, buffers {pc, instr} in a prefetch queue.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module fetch_ctrl #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_HALT
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   fetch_pc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];
   logic          full;
   logic          pop;
   logic          push;
   logic          unused_bits;

   assign unused_bits = ^redirect_pc[1:0];

   assign full      = (count == FULL_CNT);
   assign out_valid = (count != '0);
   // A head taken during a redirect is squashed, so it never advances the queue.
   assign pop       = out_valid & out_ready & ~redirect_valid;
   assign imem_addr = fetch_pc;
   assign out_pc    = q_pc[rd_ptr];
   assign out_instr = q_instr[rd_ptr];
   assign halted    = (state == S_HALT);

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      unique case (state)
         S_BOOT:  state_nxt = S_FETCH;
         S_FETCH: begin
            push = ~redirect_valid & (~full | pop);
            if (halt_req) state_nxt = S_HALT;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_BOOT;
      endcase
      if (redirect_valid) state_nxt = S_FETCH;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_BOOT;
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               q_pc[wr_ptr]    <= fetch_pc;
               q_instr[wr_ptr] <= imem_instr;
               wr_ptr          <= wr_ptr + 1'b1;
               fetch_pc        <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (push) perf_fetched <= perf_fetched + 32'd1;
         if (state == S_FETCH && full && !pop)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
